// File: rtl/sigma_delta_pkg.sv
// Shared sigma-delta helpers: CIC sizing and offset-binary <-> signed conversion.
package sigma_delta_pkg;

  function automatic int unsigned log2_osr(input int unsigned osr);
    return $clog2(osr);
  endfunction

  function automatic int unsigned cic_width(input int unsigned b, input int unsigned n,
                                            input int unsigned osr);
    return b + n * $clog2(osr);
  endfunction

  // Offset binary and two's complement differ only in the MSB of a b-bit word.
  function automatic logic [31:0] flip_msb(input logic [31:0] v, input int unsigned b);
    return v ^ (32'(1) << (b - 1));
  endfunction

  function automatic logic [31:0] ob_to_signed(input logic [31:0] v, input int unsigned b);
    return flip_msb(v, b);
  endfunction

  function automatic logic [31:0] signed_to_ob(input logic [31:0] v, input int unsigned b);
    return flip_msb(v, b);
  endfunction

endpackage

// File: rtl/sigma_delta_dac_cic.sv
// CIC interpolator: tick-rate comb chain, zero-stuffing, clk-rate integrators, saturated output.
module cic_interpolator
  import sigma_delta_pkg::*;
#(
  parameter int unsigned OSR = 256,
  parameter int unsigned N   = 2,
  parameter int unsigned B   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic signed [B-1:0] din,
  output logic signed [B-1:0] dout
);

  localparam int unsigned LOG2  = log2_osr(OSR);
  localparam int unsigned W     = cic_width(B, N, OSR);
  localparam int unsigned SHIFT = (N - 1) * LOG2;

  logic signed [W-1:0] comb_dly [N];
  logic signed [W-1:0] comb_tap [N];
  logic signed [W-1:0] comb_acc;
  logic signed [W-1:0] comb_out;
  logic                stuff_en;
  logic signed [W-1:0] integ [N];
  logic signed [W-1:0] shifted;
  logic signed [B-1:0] y_sat;

  // Comb chain evaluated on the incoming sample; taps feed the tick-rate delays.
  always_comb begin
    comb_acc = W'(din);
    for (int i = 0; i < N; i++) begin
      comb_tap[i] = comb_acc;
      comb_acc    = comb_acc - comb_dly[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_out <= '0;
      stuff_en <= 1'b0;
      for (int i = 0; i < N; i++) begin
        comb_dly[i] <= '0;
        integ[i]    <= '0;
      end
    end else begin
      stuff_en <= tick;
      if (tick) begin
        comb_out <= comb_acc;
        for (int i = 0; i < N; i++) comb_dly[i] <= comb_tap[i];
      end
      integ[0] <= integ[0] + (stuff_en ? comb_out : '0);
      for (int i = 1; i < N; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Drop the OSR^(N-1) gain, then clamp to the sample range.
  assign shifted = integ[N-1] >>> SHIFT;

  always_comb begin
    y_sat = shifted[B-1:0];
    if (shifted[W-1:B-1] != {(W-B+1){shifted[W-1]}})
      y_sat = shifted[W-1] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= y_sat;
  end

endmodule

// File: rtl/sigma_delta_dac.sv
// 1-bit sigma-delta DAC: sample handshake, tick counter, CIC interpolator and modulator.
// Define SIGMA_DELTA_DAC_2ND_ORDER_EN for a second-order modulator (first-order otherwise).
module sigma_delta_dac
  import sigma_delta_pkg::*;
#(
  parameter int unsigned OVERSAMPLE_RATE = 256,
  parameter int unsigned CIC_STAGES      = 2,
  parameter int unsigned DAC_BITLEN      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DAC_BITLEN-1:0] dac_input,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic                  dac_underflow,
  output logic                  dac_pin
);

  localparam int unsigned B     = DAC_BITLEN;
  localparam int unsigned CNT_W = log2_osr(OVERSAMPLE_RATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_RATE - 1);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next_c;
  logic                tick_c;
  logic                accept_c;
  logic                full;
  logic                full_next_c;
  logic                underflow_c;
  logic [B-1:0]        hold;
  logic signed [B-1:0] last_x;
  logic signed [B-1:0] cic_in_c;
  logic signed [B-1:0] y;

  assign cnt_next_c = cnt + CNT_W'(1);
  assign tick_c     = (cnt == CNT_LAST);
  assign accept_c   = dac_valid & dac_ready;

  // Sample source at tick: holding register, then bypass, then repeat-last.
  always_comb begin
    cic_in_c    = last_x;
    full_next_c = full;
    underflow_c = 1'b0;
    if (tick_c) begin
      if (full) begin
        cic_in_c    = B'(ob_to_signed(32'(hold), B));
        full_next_c = accept_c;
      end else if (dac_valid) begin
        cic_in_c    = B'(ob_to_signed(32'(dac_input), B));
      end else begin
        underflow_c = 1'b1;
      end
    end else if (accept_c) begin
      full_next_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      full          <= 1'b0;
      hold          <= '0;
      last_x        <= '0;
      dac_ready     <= 1'b1;
      dac_underflow <= 1'b0;
    end else begin
      cnt           <= cnt_next_c;
      full          <= full_next_c;
      dac_underflow <= underflow_c;
      // Ready is precomputed from next-cycle state so it never depends on valid.
      dac_ready     <= !full_next_c | (cnt_next_c == CNT_LAST);
      if (accept_c && full_next_c) hold <= dac_input;
      if (tick_c) last_x <= cic_in_c;
    end
  end

  cic_interpolator #(
    .OSR (OVERSAMPLE_RATE),
    .N   (CIC_STAGES),
    .B   (B)
  ) u_cic (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_c),
    .din   (cic_in_c),
    .dout  (y)
  );

`ifdef SIGMA_DELTA_DAC_2ND_ORDER_EN
  localparam int unsigned EW = B + 4;
  localparam logic signed [EW-1:0] FB_POS = EW'(64'(1) << (B - 1));

  logic signed [EW-1:0] e1;
  logic signed [EW-1:0] e2;
  logic signed [EW-1:0] fb_c;
  logic signed [EW-1:0] e1_next_c;
  logic signed [EW-1:0] e2_next_c;

  function automatic logic signed [EW-1:0] sat_sum(input logic signed [EW-1:0] a,
                                                   input logic signed [EW-1:0] b,
                                                   input logic signed [EW-1:0] c);
    logic signed [EW+1:0] s;
    s = (EW+2)'(a) + (EW+2)'(b) - (EW+2)'(c);
    if (s[EW+1:EW-1] != {3{s[EW+1]}})
      return s[EW+1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
    return s[EW-1:0];
  endfunction

  assign fb_c      = dac_pin ? FB_POS : -FB_POS;
  assign e1_next_c = sat_sum(e1, EW'(y), fb_c);
  assign e2_next_c = sat_sum(e2, e1_next_c, fb_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1      <= '0;
      e2      <= '0;
      dac_pin <= 1'b0;
    end else begin
      e1      <= e1_next_c;
      e2      <= e2_next_c;
      dac_pin <= !e2_next_c[EW-1];
    end
  end
`else
  logic [B-1:0] acc;
  logic [B:0]   acc_next_c;

  // Carry out of the phase accumulator is the output bit.
  assign acc_next_c = {1'b0, acc} + {1'b0, B'(signed_to_ob(32'(y), B))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      dac_pin <= 1'b0;
    end else begin
      acc     <= acc_next_c[B-1:0];
      dac_pin <= acc_next_c[B];
    end
  end
`endif

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Self-checking bench for sigma_delta_dac: cycle-level behavioural model plus spot checks.
module tb_sigma_delta_dac;

  localparam int unsigned OSR = 256;
  localparam int unsigned NST = 2;
  localparam int unsigned B   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dac_input = '0;
  logic        dac_valid = 1'b0;
  logic        dac_ready;
  logic        dac_underflow;
  logic        dac_pin;

  always #5 clk = ~clk;

  sigma_delta_dac #(
    .OVERSAMPLE_RATE (OSR),
    .CIC_STAGES      (NST),
    .DAC_BITLEN      (B)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dac_input     (dac_input),
    .dac_valid     (dac_valid),
    .dac_ready     (dac_ready),
    .dac_underflow (dac_underflow),
    .dac_pin       (dac_pin)
  );

  int npass = 0;
  int ntotal = 0;

  task automatic check(input string name, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    ntotal++;
    if (act >= lo && act <= hi) npass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Model: sample queue, linear interpolation between consecutive samples, phase accumulator.
  int     ph;
  longint hold_q[$];
  longint consumed[$];
  longint last_s, pend_s, xa, xb, int2, yreg, acc;
  int     j;
  bit     pend, m_pin, m_ready, m_under;

  always @(posedge clk or negedge rst_n) begin
    bit     tick, acc_ok;
    longint s, in_s;
    if (!rst_n) begin
      ph = 0; hold_q.delete(); last_s = 0; pend = 0; pend_s = 0;
      xa = 0; xb = 0; j = 0; int2 = 0; yreg = 0; acc = 0;
      m_pin = 0; m_ready = 1; m_under = 0;
    end else begin
      tick   = (ph == OSR - 1);
      in_s   = longint'(dac_input) - 32768;
      acc_ok = dac_valid && m_ready;
      m_under = 0;
      acc   = acc + (yreg + 32768);
      m_pin = (acc >= 65536);
      acc   = acc % 65536;
      yreg  = sat16(int2 >>> 8);
      j++;
      int2 = longint'(OSR) * xa + longint'(j) * (xb - xa);
      if (pend) begin
        xa = xb; xb = pend_s; j = 0; pend = 0;
      end
      if (tick) begin
        if (hold_q.size() > 0) begin
          s = hold_q.pop_front();
          if (acc_ok) hold_q.push_back(in_s);
        end else if (dac_valid) begin
          s = in_s;
        end else begin
          s = last_s;
          m_under = 1;
        end
        last_s = s; pend = 1; pend_s = s;
        consumed.push_back(s);
      end else if (acc_ok) begin
        hold_q.push_back(in_s);
      end
      ph = (ph + 1) % OSR;
      m_ready = (hold_q.size() == 0) || (ph == OSR - 1);
    end
  end

  bit cmp_on = 0;

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      check("pin", dac_pin, m_pin);
      check("ready", dac_ready, m_ready);
      check("underflow", dac_underflow, m_under);
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input int n);
    repeat (n) begin
      @(negedge clk);
      dac_valid = v;
      dac_input = d;
    end
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += dac_pin;
    end
  endtask

  logic [15:0] bp_data;
  int bp_acc, bp_und;

  task automatic bp_run(input int n);
    bit r;
    bp_acc = 0; bp_und = 0;
    repeat (n) begin
      r = dac_ready;
      @(negedge clk);
      if (r) begin
        bp_acc++;
        bp_data = bp_data + 16'd1;
      end
      bp_und += dac_underflow;
      dac_input = bp_data;
    end
  endtask

  initial begin
    int ones, unders, k;
    // Reset
    repeat (5) @(negedge clk);
    check("rst_pin", dac_pin, 0);
    check("rst_ready", dac_ready, 1);
    check("rst_underflow", dac_underflow, 0);
    rst_n = 1'b1;
    cmp_on = 1;

    // Idle: midscale alternation and one underflow per sample period
    unders = 0;
    for (int i = 1; i <= 512; i++) begin
      @(negedge clk);
      if (i <= 8) check("idle_alternate", dac_pin, (i % 2 == 0) ? 1 : 0);
      unders += dac_underflow;
    end
    check("idle_underflows", unders, 2);

    // Back-pressure: valid held high, data increments on each accept
    consumed.delete();
    bp_data = 16'h1000;
    dac_input = bp_data;
    dac_valid = 1'b1;
    bp_run(300);
    consumed.delete();
    bp_run(1024);
    check("bp_accepts", bp_acc, 4);
    check("bp_underflows", bp_und, 0);
    for (int i = 1; i < consumed.size(); i++)
      check("bp_sequence_step", consumed[i] - consumed[i-1], 1);

    // Constant 0xC000
    drive(1'b1, 16'hC000, 1200);
    check("model_y_c000", yreg, 16384);
    count_ones(256, ones);
    check_range("ones_c000", ones, 191, 193);

    // Full scale low, then step to full scale high
    drive(1'b1, 16'h0000, 1200);
    count_ones(256, ones);
    check("ones_zero", ones, 0);
    drive(1'b1, 16'hFFFF, 1200);
    count_ones(256, ones);
    check_range("ones_full", ones, 255, 256);

    // Bypass: empty buffer, valid only on the tick cycle
    drive(1'b1, 16'h8000, 600);
    drive(1'b0, 16'h8000, 600);
    k = 0;
    while (ph != OSR - 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("bypass_phase_found", ph, OSR - 1);
    dac_valid = 1'b1;
    dac_input = 16'hE000;
    @(negedge clk);
    dac_valid = 1'b0;
    check("bypass_underflow", dac_underflow, 0);
    check("bypass_ready", dac_ready, 1);
    @(negedge clk);
    @(negedge clk);
    check("bypass_y_t2", yreg, 0);
    @(negedge clk);
    check("bypass_y_t3", yreg, 96);
    drive(1'b0, 16'h0000, 300);

    // Random traffic: sparse then dense
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      dac_valid = ($urandom_range(0, 299) == 0);
      dac_input = 16'($urandom);
    end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      dac_valid = ($urandom_range(0, 99) < 60);
      dac_input = 16'($urandom);
    end

    // Reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pin", dac_pin, 0);
    check("midrst_ready", dac_ready, 1);
    check("midrst_underflow", dac_underflow, 0);
    dac_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      dac_valid = ($urandom_range(0, 199) == 0);
      dac_input = 16'($urandom);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
